count_stream_checker: RTL and testbench

//  Receiving end of the free-running counter interface: samples a W-bit count stream and checks it

---
 rtl/count_stream_checker.sv | 106 ++++++++++
 tb/tb_count_stream_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/count_stream_checker.sv
// count_stream_checker: in-system checker for a free-running W-bit counter stream.
// It accepts a step of +1 per valid sample, including the wrap from 2^W-1 to 0.
// It locks after LOCK_LEN consecutive good steps.
// While locked, every break in the sequence pulses err and bumps the saturating err_cnt.
// Optional feature macro: CNT_CHK_RESTART_EN. When it is defined, a locked stream that
// jumps to 0 is treated as a counter restart and re-acquired without flagging an error.
module count_stream_checker #(
    parameter int unsigned W        = 4,
    parameter int unsigned LOCK_LEN = 3,
    parameter int unsigned ERRW     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [W-1:0]    count_in,
    output logic            locked,
    output logic            err,
    output logic [ERRW-1:0] err_cnt,
    output logic [W-1:0]    expected
);

    // Run counter wide enough for LOCK_LEN up to 15.
    localparam int unsigned RUNW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [RUNW-1:0]   run;

    logic [W-1:0]      next_exp;
    logic [RUNW-1:0]   run_inc;
    logic              match;
    logic              restart;
    logic              err_cnt_max;

    // Step arithmetic and comparison of the current sample.
    assign next_exp    = count_in + W'(1);
    assign run_inc     = run + RUNW'(1);
    assign match       = (count_in == expected);
    assign err_cnt_max = &err_cnt;

`ifdef CNT_CHK_RESTART_EN
    // A jump to 0 while locked is a restart of the observed counter.
    assign restart = (count_in == '0);
`else
    assign restart = 1'b0;
`endif

    // Tracking FSM with registered outputs; err defaults low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            run      <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            expected <= '0;
        end else begin
            err <= 1'b0;
            if (valid_in) begin
                // Every accepted sample re-anchors the expectation.
                expected <= next_exp;
                case (state)
                    IDLE: begin
                        run   <= '0;
                        state <= ACQ;
                    end
                    ACQ: begin
                        if (match) begin
                            run <= run_inc;
                            if (run_inc == RUNW'(LOCK_LEN)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!match) begin
                            run    <= '0;
                            state  <= ACQ;
                            locked <= 1'b0;
                            if (!restart) begin
                                err <= 1'b1;
                                if (!err_cnt_max) begin
                                    err_cnt <= err_cnt + ERRW'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        run    <= '0;
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_stream_checker.sv
// Bench for count_stream_checker: a rule-level reference model checked every cycle, plus directed literals.
module tb_count_stream_checker;

    localparam int unsigned W        = 4;
    localparam int unsigned LOCK_LEN = 3;
    localparam int unsigned ERRW     = 2;
    localparam int          MODV     = 1 << W;
    localparam int          CNT_MAX  = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_in;
    logic [W-1:0]    count_in;
    logic            locked;
    logic            err;
    logic [ERRW-1:0] err_cnt;
    logic [W-1:0]    expected;

    count_stream_checker #(.W(W), .LOCK_LEN(LOCK_LEN), .ERRW(ERRW)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .count_in (count_in),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .expected (expected)
    );

    always #5 clk = ~clk;

    // Reference model: what the outputs must be after each clock edge.
    int m_exp    = 0;
    int m_streak = 0;
    int m_cnt    = 0;
    int m_c      = 0;
    bit m_seen   = 0;
    bit m_locked = 0;
    bit m_err    = 0;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 0;

    always @(posedge clk) begin
        m_err = 0;
        if (reset) begin
            m_exp = 0; m_streak = 0; m_cnt = 0; m_seen = 0; m_locked = 0;
        end else if (valid_in) begin
            m_c = int'(count_in);
            if (!m_seen) begin
                m_seen   = 1;
                m_streak = 0;
            end else if (m_locked) begin
                if (m_c != m_exp) begin
                    m_locked = 0;
                    m_streak = 0;
`ifdef CNT_CHK_RESTART_EN
                    if (m_c != 0) begin
                        m_err = 1;
                        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                    end
`else
                    m_err = 1;
                    if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`endif
                end
            end else begin
                if (m_c == m_exp) begin
                    m_streak = m_streak + 1;
                    if (m_streak >= LOCK_LEN) m_locked = 1;
                end else begin
                    m_streak = 0;
                end
            end
            m_exp = (m_c + 1) % MODV;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    endtask

    // Continuous comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_locked",   int'(locked),   int'(m_locked));
            check("model_err",      int'(err),      int'(m_err));
            check("model_err_cnt",  int'(err_cnt),  m_cnt);
            check("model_expected", int'(expected), m_exp);
        end
    end

    task automatic cyc(input bit r, input bit v, input int c);
        @(negedge clk);
        reset    = r;
        valid_in = v;
        count_in = W'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c);
        cyc(1'b0, 1'b1, c % MODV);
    endtask

    task automatic send_exp(input int n);
        repeat (n) send(m_exp);
    endtask

    int v;

    initial begin
        reset = 1'b1; valid_in = 1'b0; count_in = '0;
        cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);
        chk_en = 1;
        check("rst_locked",   int'(locked),   0);
        check("rst_err",      int'(err),      0);
        check("rst_err_cnt",  int'(err_cnt),  0);
        check("rst_expected", int'(expected), 0);
        cyc(1'b0, 1'b0, 0);

        // Acquire on 0,1,2,3,4
        send(0); send(1); send(2);
        check("t1_not_yet_locked", int'(locked), 0);
        send(3);
        check("t1_locked", int'(locked), 1);
        send(4);
        check("t1_expected", int'(expected), 5);

        // Wrap 15 -> 0 while locked
        for (int c = 5; c <= 12; c++) send(c);
        send(13); send(14); send(15); send(0); send(1);
        check("t2_locked",   int'(locked),   1);
        check("t2_expected", int'(expected), 2);

        // Mismatch while locked, then re-lock
        send(2); send(3); send(4); send(5);
        check("t3_pre_expected", int'(expected), 6);
        send(9);
        check("t3_err",      int'(err),      1);
        check("t3_err_cnt",  int'(err_cnt),  1);
        check("t3_locked",   int'(locked),   0);
        check("t3_expected", int'(expected), 10);
        send(10);
        check("t3_err_one_cycle", int'(err), 0);
        send(11);
        check("t3_still_acq", int'(locked), 0);
        send(12);
        check("t3_relocked", int'(locked), 1);

        // Jump to 0 while locked at expected 7
        for (int c = 13; c <= 22; c++) send(c);
        check("t4_pre_expected", int'(expected), 7);
        send(0);
        check("t4_locked",   int'(locked),   0);
        check("t4_expected", int'(expected), 1);
`ifdef CNT_CHK_RESTART_EN
        check("t4_err",     int'(err),     0);
        check("t4_err_cnt", int'(err_cnt), 1);
`else
        check("t4_err",     int'(err),     1);
        check("t4_err_cnt", int'(err_cnt), 2);
`endif
        send(1); send(2); send(3);
        check("t4_relocked", int'(locked), 1);

        // valid_in low: everything holds, lock kept on resume
        repeat (5) cyc(1'b0, 1'b0, 9);
        check("t5_hold_expected", int'(expected), 4);
        check("t5_hold_locked",   int'(locked),   1);
        send(4);
        check("t5_resume_locked",   int'(locked),   1);
        check("t5_resume_expected", int'(expected), 5);

        // Repeated value is a mismatch
        send(4);
        check("rep_err",    int'(err),    1);
        check("rep_locked", int'(locked), 0);
        // Mismatch during acquisition: no error
        send(9);
        check("acq_mismatch_err", int'(err), 0);

        // Drive err_cnt into saturation
        for (int i = 0; i < 3; i++) begin
            send_exp(3);
            v = (m_exp + 2) % MODV;
            if (v == 0) v = 1;
            send(v);
        end
        check("sat_err_cnt", int'(err_cnt), CNT_MAX);
        check("sat_err",     int'(err),     1);

        // Reset while locked with a valid in-sequence sample present
        send_exp(3);
        check("t6_pre_locked", int'(locked), 1);
        cyc(1'b1, 1'b1, m_exp);
        check("t6_locked",   int'(locked),   0);
        check("t6_err_cnt",  int'(err_cnt),  0);
        check("t6_expected", int'(expected), 0);
        cyc(1'b0, 1'b0, 0);
        send(7);
        check("t6_idle_expected", int'(expected), 8);
        check("t6_idle_locked",   int'(locked),   0);
        cyc(1'b0, 1'b0, 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
